// File: rtl/segre_pkg.sv
// Shared types and constants for the segre store buffer and its lookup logic.
package segre_pkg;

  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  localparam int unsigned SB_NUM_ELEMS       = 4;
  localparam int unsigned SB_DRAIN_THRESHOLD = 2;
  localparam int unsigned SB_PTR             = $clog2(SB_NUM_ELEMS);

  typedef enum logic {
    SB_RUN,
    SB_FENCE
  } sb_fsm_state_e;

  typedef struct packed {
    logic                   valid;
    logic [ADDR_SIZE-3:0]   waddr;
    logic [3:0]             be;
    logic [WORD_SIZE-1:0]   data;
  } sb_entry_t;

  function automatic logic [3:0] memop_be(input memop_data_type_e t, input logic [1:0] a);
    logic [3:0] be;
    case (t)
      BYTE:    be = 4'b0001 << a;
      HALF:    be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic memop_misaligned(input memop_data_type_e t, input logic [1:0] a);
    logic mis;
    case (t)
      BYTE:    mis = 1'b0;
      HALF:    mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] memop_width_mask(input memop_data_type_e t);
    logic [31:0] m;
    case (t)
      BYTE:    m = 32'h0000_00ff;
      HALF:    m = 32'h0000_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/segre_sb_lookup.sv
// Combinational youngest-match search over the store buffer, plus alignment and
// lane formatting of the incoming store and of the forwarded load data.
module segre_sb_lookup
  import segre_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                                   req_store,
  input  logic                                   req_load,
  input  logic [ADDR_SIZE-1:0]                   addr,
  input  logic [WORD_SIZE-1:0]                   wdata,
  input  logic [1:0]                             memop_type,
  input  logic [$clog2(NUM_ELEMS)-1:0]           head,
  input  logic [NUM_ELEMS-1:0]                   ent_valid,
  input  logic [NUM_ELEMS-1:0][ADDR_SIZE-3:0]    ent_waddr,
  input  logic [NUM_ELEMS-1:0][3:0]              ent_be,
  input  logic [NUM_ELEMS-1:0][WORD_SIZE-1:0]    ent_data,
  output logic                                   misaligned,
  output logic                                   hit,
  output logic                                   miss,
  output logic                                   trouble,
  output logic [WORD_SIZE-1:0]                   data_load,
  output logic [3:0]                             store_be,
  output logic [WORD_SIZE-1:0]                   store_data
);

  localparam int unsigned PtrW = $clog2(NUM_ELEMS);

  memop_data_type_e     mtype;
  logic [1:0]           lane;
  logic                 mis;
  logic [3:0]           ld_be;
  logic [WORD_SIZE-1:0] width_mask;
  logic [PtrW-1:0]      idx;
  logic                 found;
  logic [3:0]           m_be;
  logic [WORD_SIZE-1:0] m_data;
  logic                 active;
  logic                 covered;

  always_comb begin
    mtype      = memop_data_type_e'(memop_type);
    lane       = addr[1:0];
    mis        = memop_misaligned(mtype, lane);
    ld_be      = memop_be(mtype, lane);
    width_mask = WORD_SIZE'(memop_width_mask(mtype));

    misaligned = (req_store | req_load) & mis;
    store_be   = ld_be;
    store_data = (wdata & width_mask) << {lane, 3'b000};

    // Walk oldest to youngest so the last overlapping entry wins.
    idx    = '0;
    found  = 1'b0;
    m_be   = '0;
    m_data = '0;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      idx = head + PtrW'(i);
      if (ent_valid[idx] && (ent_waddr[idx] == addr[ADDR_SIZE-1:2]) &&
          ((ent_be[idx] & ld_be) != 4'b0000)) begin
        found  = 1'b1;
        m_be   = ent_be[idx];
        m_data = ent_data[idx];
      end
    end

    active    = req_load & ~mis;
    covered   = ((ld_be & ~m_be) == 4'b0000);
    miss      = active & ~found;
    hit       = active & found & covered;
    trouble   = active & found & ~covered;
    data_load = hit ? ((m_data >> {lane, 3'b000}) & width_mask) : '0;
  end

endmodule

// File: rtl/segre_store_buffer_fifo.sv
// Circular store buffer: enqueues retired stores, drains the head to the data
// cache, forwards to younger loads and supports a drain-all fence.
module segre_store_buffer_fifo
  import segre_pkg::*;
#(
  parameter int unsigned NUM_ELEMS       = 4,
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned DRAIN_THRESHOLD = 2
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 req_store_i,
  input  logic                 req_load_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [1:0]           memop_type_i,
  input  logic                 flush_chance_i,
  input  logic                 fence_i,
  output logic                 store_ready_o,
  output logic                 misaligned_o,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic                 trouble_o,
  output logic [WORD_SIZE-1:0] data_load_o,
  output logic                 flush_valid_o,
  input  logic                 flush_ready_i,
  output logic [ADDR_SIZE-1:0] flush_addr_o,
  output logic [WORD_SIZE-1:0] flush_data_o,
  output logic [3:0]           flush_be_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 fence_done_o
);

  localparam int unsigned PtrW = $clog2(NUM_ELEMS);
  localparam int unsigned CntW = PtrW + 1;

  logic [NUM_ELEMS-1:0]                valid_q;
  logic [NUM_ELEMS-1:0][ADDR_SIZE-3:0] waddr_q;
  logic [NUM_ELEMS-1:0][3:0]           be_q;
  logic [NUM_ELEMS-1:0][WORD_SIZE-1:0] data_q;

  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  sb_fsm_state_e   state_q, state_d;

  logic                 push, pop;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_data;

  segre_sb_lookup #(
    .NUM_ELEMS (NUM_ELEMS),
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_lookup (
    .req_store  (req_store_i),
    .req_load   (req_load_i),
    .addr       (addr_i),
    .wdata      (data_i),
    .memop_type (memop_type_i),
    .head       (head_q),
    .ent_valid  (valid_q),
    .ent_waddr  (waddr_q),
    .ent_be     (be_q),
    .ent_data   (data_q),
    .misaligned (misaligned_o),
    .hit        (hit_o),
    .miss       (miss_o),
    .trouble    (trouble_o),
    .data_load  (data_load_o),
    .store_be   (st_be),
    .store_data (st_data)
  );

  always_comb begin
    full_o        = (count_q == CntW'(NUM_ELEMS));
    empty_o       = (count_q == '0);
    flush_valid_o = ~empty_o & ((state_q == SB_FENCE) ||
                                (count_q >= CntW'(DRAIN_THRESHOLD)) || flush_chance_i);
    pop           = flush_valid_o & flush_ready_i;
    store_ready_o = (state_q == SB_RUN) & (~full_o | pop);
    push          = req_store_i & store_ready_o & ~misaligned_o;
    count_d       = count_q + CntW'(push) - CntW'(pop);

    flush_addr_o  = flush_valid_o ? {waddr_q[head_q], 2'b00} : '0;
    flush_data_o  = flush_valid_o ? data_q[head_q] : '0;
    flush_be_o    = flush_valid_o ? be_q[head_q] : '0;
  end

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    unique case (state_q)
      SB_RUN: begin
        if (fence_i) state_d = SB_FENCE;
      end
      SB_FENCE: begin
        if (empty_o) begin
          state_d      = SB_RUN;
          fence_done_o = 1'b1;
        end
      end
      default: state_d = SB_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= SB_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop)  head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + 1'b1;
    end
  end

  // Pop clears before push sets: when full, tail equals head and the new entry must survive.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      waddr_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      if (pop) valid_q[head_q] <= 1'b0;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        waddr_q[tail_q] <= addr_i[ADDR_SIZE-1:2];
        be_q[tail_q]    <= st_be;
        data_q[tail_q]  <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_segre_store_buffer_fifo.sv
// Directed bench for segre_store_buffer_fifo with hand-computed expectations.
module tb_segre_store_buffer_fifo;
  import segre_pkg::*;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        req_store, req_load, flush_chance, fence, flush_ready;
  logic [31:0] addr, data;
  logic [1:0]  memop_type;
  logic        store_ready, misaligned, hit, miss, trouble;
  logic [31:0] data_load, flush_addr, flush_data;
  logic        flush_valid, full, empty, fence_done;
  logic [3:0]  flush_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  segre_store_buffer_fifo #(
    .NUM_ELEMS       (4),
    .ADDR_SIZE       (32),
    .WORD_SIZE       (32),
    .DRAIN_THRESHOLD (2)
  ) dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .req_store_i    (req_store),
    .req_load_i     (req_load),
    .addr_i         (addr),
    .data_i         (data),
    .memop_type_i   (memop_type),
    .flush_chance_i (flush_chance),
    .fence_i        (fence),
    .store_ready_o  (store_ready),
    .misaligned_o   (misaligned),
    .hit_o          (hit),
    .miss_o         (miss),
    .trouble_o      (trouble),
    .data_load_o    (data_load),
    .flush_valid_o  (flush_valid),
    .flush_ready_i  (flush_ready),
    .flush_addr_o   (flush_addr),
    .flush_data_o   (flush_data),
    .flush_be_o     (flush_be),
    .full_o         (full),
    .empty_o        (empty),
    .fence_done_o   (fence_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_store = 1'b0; req_load = 1'b0; flush_chance = 1'b0; fence = 1'b0;
    flush_ready = 1'b0; addr = '0; data = '0; memop_type = WORD;
  endtask

  task automatic do_reset();
    idle_inputs();
    rsn = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    req_store = 1'b1; addr = a; memop_type = t; data = d;
    tick();
    req_store = 1'b0;
    #1;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [1:0] t,
                            input logic eh, input logic em, input logic et,
                            input logic [31:0] ed);
    req_load = 1'b1; addr = a; memop_type = t;
    #1;
    check_eq({tag, "_hit"}, 32'(hit), 32'(eh));
    check_eq({tag, "_miss"}, 32'(miss), 32'(em));
    check_eq({tag, "_trouble"}, 32'(trouble), 32'(et));
    check_eq({tag, "_data"}, data_load, ed);
    req_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    #1;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_flush_valid", 32'(flush_valid), 32'd0);
    check_eq("rst_fence_done", 32'(fence_done), 32'd0);
    check_eq("rst_store_ready", 32'(store_ready), 32'd1);
    check_eq("rst_hmt", {29'd0, hit, miss, trouble}, 32'd0);
    check_eq("rst_flush_addr", flush_addr, 32'd0);
    @(negedge clk);
    rsn = 1'b1;
    #1;

    // Word store forward, then youngest-byte wins.
    store(32'h100, WORD, 32'hDEADBEEF);
    load_check("lw_100", 32'h100, WORD, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    check_eq("one_no_drain", 32'(flush_valid), 32'd0);
    store(32'h101, BYTE, 32'hAA);
    store(32'h101, BYTE, 32'h55);
    load_check("lbu_101", 32'h101, BYTE, 1'b1, 1'b0, 1'b0, 32'h55);
    load_check("lbu_100", 32'h100, BYTE, 1'b1, 1'b0, 1'b0, 32'hEF);
    load_check("lh_100", 32'h100, HALF, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("thr_valid", 32'(flush_valid), 32'd1);
    check_eq("thr_addr", flush_addr, 32'h100);
    check_eq("thr_be", 32'(flush_be), 32'hF);
    check_eq("thr_data", flush_data, 32'hDEADBEEF);

    // Partial overlap, miss, disjoint lanes.
    do_reset();
    store(32'h200, HALF, 32'h1234);
    load_check("lw_200", 32'h200, WORD, 1'b0, 1'b0, 1'b1, 32'h0);
    load_check("lw_300", 32'h300, WORD, 1'b0, 1'b1, 1'b0, 32'h0);
    load_check("lh_202", 32'h202, HALF, 1'b0, 1'b1, 1'b0, 32'h0);
    load_check("lbu_201", 32'h201, BYTE, 1'b1, 1'b0, 1'b0, 32'h12);

    // Full, then push+pop in one cycle.
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), WORD, 32'(i + 1));
    check_eq("full", 32'(full), 32'd1);
    check_eq("full_not_ready", 32'(store_ready), 32'd0);
    check_eq("full_head", flush_addr, 32'h10);
    req_store = 1'b1; addr = 32'h20; data = 32'd5; memop_type = WORD; flush_ready = 1'b1;
    #1;
    check_eq("pushpop_ready", 32'(store_ready), 32'd1);
    tick();
    req_store = 1'b0; flush_ready = 1'b0;
    #1;
    check_eq("pushpop_full", 32'(full), 32'd1);
    check_eq("pushpop_head", flush_addr, 32'h14);
    check_eq("pushpop_hdata", flush_data, 32'd2);
    tick();
    check_eq("stall_head", flush_addr, 32'h14);
    load_check("lw_20", 32'h20, WORD, 1'b1, 1'b0, 1'b0, 32'd5);

    // Fence drains three entries in order.
    do_reset();
    store(32'h40, BYTE, 32'h11);
    store(32'h46, HALF, 32'hBEEF);
    store(32'h48, WORD, 32'hCAFEF00D);
    fence = 1'b1;
    tick();
    fence = 1'b0;
    flush_ready = 1'b1;
    req_store = 1'b1; addr = 32'h60; data = 32'h1; memop_type = WORD;
    #1;
    check_eq("fence_refuse", 32'(store_ready), 32'd0);
    check_eq("pop0_addr", flush_addr, 32'h40);
    check_eq("pop0_be", 32'(flush_be), 32'h1);
    check_eq("pop0_data", flush_data, 32'h11);
    req_store = 1'b0;
    load_check("fence_lbu", 32'h40, BYTE, 1'b1, 1'b0, 1'b0, 32'h11);
    req_store = 1'b1; addr = 32'h60; memop_type = WORD;
    tick();
    check_eq("pop1_addr", flush_addr, 32'h44);
    check_eq("pop1_be", 32'(flush_be), 32'hC);
    check_eq("pop1_data", flush_data, 32'hBEEF0000);
    tick();
    check_eq("pop2_addr", flush_addr, 32'h48);
    check_eq("pop2_be", 32'(flush_be), 32'hF);
    check_eq("pop2_done_early", 32'(fence_done), 32'd0);
    tick();
    check_eq("fence_done", 32'(fence_done), 32'd1);
    check_eq("fence_empty", 32'(empty), 32'd1);
    check_eq("fence_still_refuse", 32'(store_ready), 32'd0);
    req_store = 1'b0; flush_ready = 1'b0;
    tick();
    check_eq("fence_done_once", 32'(fence_done), 32'd0);
    check_eq("fence_ready_again", 32'(store_ready), 32'd1);
    check_eq("fence_no_push", 32'(empty), 32'd1);

    // Fence while empty.
    fence = 1'b1;
    tick();
    fence = 1'b0;
    #1;
    check_eq("efence_done", 32'(fence_done), 32'd1);
    check_eq("efence_refuse", 32'(store_ready), 32'd0);
    tick();
    check_eq("efence_done_once", 32'(fence_done), 32'd0);
    check_eq("efence_ready", 32'(store_ready), 32'd1);

    // Misaligned store and load.
    req_store = 1'b1; addr = 32'h103; memop_type = HALF; data = 32'h1;
    #1;
    check_eq("mis_store", 32'(misaligned), 32'd1);
    tick();
    req_store = 1'b0;
    #1;
    check_eq("mis_no_enq", 32'(empty), 32'd1);
    req_load = 1'b1; addr = 32'h102; memop_type = WORD;
    #1;
    check_eq("mis_load", 32'(misaligned), 32'd1);
    check_eq("mis_load_hmt", {29'd0, hit, miss, trouble}, 32'd0);
    req_load = 1'b0;

    // Reset mid-fence.
    store(32'h80, WORD, 32'h1);
    store(32'h84, WORD, 32'h2);
    fence = 1'b1;
    tick();
    fence = 1'b0;
    #1;
    check_eq("mf_not_empty", 32'(empty), 32'd0);
    rsn = 1'b0;
    #1;
    check_eq("mf_empty", 32'(empty), 32'd1);
    check_eq("mf_no_done", 32'(fence_done), 32'd0);
    @(negedge clk);
    rsn = 1'b1;
    #1;
    check_eq("mf_ready", 32'(store_ready), 32'd1);
    tick();
    check_eq("mf_no_done_late", 32'(fence_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
